// File: rtl/sme_sched_if.sv
// Requester, engine and result signals of the match-engine scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface sme_sched_if;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic [7:0] in_data0, in_data1;
  logic       in_str0, in_str1;
  logic       in_pat0, in_pat1;
  logic       in_last0, in_last1;
  logic [7:0] eng_chardata;
  logic       eng_isstring, eng_ispattern;
  logic       eng_valid, eng_match;
  logic [4:0] eng_match_index;
  logic       res_valid0, res_valid1;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       busy;

  modport slave (
    input  req0, req1, in_data0, in_data1, in_str0, in_str1, in_pat0, in_pat1,
           in_last0, in_last1, eng_valid, eng_match, eng_match_index,
    output gnt0, gnt1, eng_chardata, eng_isstring, eng_ispattern,
           res_valid0, res_valid1, res_match, res_index, res_err, busy
  );

  modport master (
    output req0, req1, in_data0, in_data1, in_str0, in_str1, in_pat0, in_pat1,
           in_last0, in_last1, eng_valid, eng_match, eng_match_index,
    input  gnt0, gnt1, eng_chardata, eng_isstring, eng_ispattern,
           res_valid0, res_valid1, res_match, res_index, res_err, busy
  );
endinterface

// File: rtl/sme_sched.sv
// Two-requester round-robin scheduler for a string-match engine: streams the owner's bytes
// to the engine one cycle late, waits for the engine result (with timeout), reports it.
module sme_sched #(
  parameter int unsigned TMO = 64
) (
  input logic        clk,
  input logic        reset,
  sme_sched_if.slave bus_io
);

  localparam int unsigned CntW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StWait, StResult} state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [7:0]      eng_data_q, eng_data_d;
  logic            eng_str_q, eng_str_d;
  logic            eng_pat_q, eng_pat_d;
  logic [5:0]      str_cnt_q, str_cnt_d;
  logic [3:0]      pat_cnt_q, pat_cnt_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            res_match_q, res_match_d;
  logic [4:0]      res_index_q, res_index_d;
  logic            res_err_q, res_err_d;

  logic [7:0] sel_data;
  logic       sel_str, sel_pat, sel_last;
  logic       pick;
  logic       proto_err;

  // Only the owner's lanes are looked at; the other requester is ignored while streaming.
  assign sel_data = owner_q ? bus_io.in_data1 : bus_io.in_data0;
  assign sel_str  = owner_q ? bus_io.in_str1  : bus_io.in_str0;
  assign sel_pat  = owner_q ? bus_io.in_pat1  : bus_io.in_pat0;
  assign sel_last = owner_q ? bus_io.in_last1 : bus_io.in_last0;

  assign pick = (bus_io.req0 && bus_io.req1) ? ptr_q : bus_io.req1;

  assign proto_err = (!sel_str && !sel_pat) ||
                     (sel_str && sel_pat) ||
                     (sel_str && (pat_cnt_q != 4'd0)) ||
                     (sel_str && (str_cnt_q == 6'd32)) ||
                     (sel_pat && (pat_cnt_q == 4'd8)) ||
                     (sel_pat && (str_cnt_q == 6'd0)) ||
                     (sel_last && !sel_pat);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    eng_data_d  = 8'h00;
    eng_str_d   = 1'b0;
    eng_pat_d   = 1'b0;
    str_cnt_d   = str_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req0 || bus_io.req1) begin
          owner_d   = pick;
          gnt_d     = pick ? 2'b10 : 2'b01;
          str_cnt_d = 6'd0;
          pat_cnt_d = 4'd0;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (proto_err) begin
          gnt_d       = 2'b00;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          res_err_d   = 1'b1;
          state_d     = StResult;
        end else begin
          eng_data_d = sel_data;
          eng_str_d  = sel_str;
          eng_pat_d  = sel_pat;
          if (sel_str) begin
            str_cnt_d = str_cnt_q + 6'd1;
          end else begin
            pat_cnt_d = pat_cnt_q + 4'd1;
          end
          if (sel_pat && sel_last) begin
            gnt_d      = 2'b00;
            wait_cnt_d = '0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (bus_io.eng_valid) begin
          res_match_d = bus_io.eng_match;
          res_index_d = bus_io.eng_match_index;
          res_err_d   = 1'b0;
          state_d     = StResult;
        end else if (wait_cnt_q == CntW'(TMO - 1)) begin
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          res_err_d   = 1'b1;
          state_d     = StResult;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StResult: begin
        ptr_d   = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= 2'b00;
      eng_data_q  <= 8'h00;
      eng_str_q   <= 1'b0;
      eng_pat_q   <= 1'b0;
      str_cnt_q   <= 6'd0;
      pat_cnt_q   <= 4'd0;
      wait_cnt_q  <= '0;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      eng_data_q  <= eng_data_d;
      eng_str_q   <= eng_str_d;
      eng_pat_q   <= eng_pat_d;
      str_cnt_q   <= str_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus_io.gnt0          = gnt_q[0];
  assign bus_io.gnt1          = gnt_q[1];
  assign bus_io.eng_chardata  = eng_data_q;
  assign bus_io.eng_isstring  = eng_str_q;
  assign bus_io.eng_ispattern = eng_pat_q;
  assign bus_io.res_valid0    = (state_q == StResult) && !owner_q;
  assign bus_io.res_valid1    = (state_q == StResult) && owner_q;
  assign bus_io.res_match     = res_match_q;
  assign bus_io.res_index     = res_index_q;
  assign bus_io.res_err       = res_err_q;
  assign bus_io.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sme_sched.sv
// Directed bench for sme_sched: per-cycle vector tables plus hand-written long sequences
// (string/pattern overflow, engine timeout, reset in the middle of a job).
module tb_sme_sched;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sme_sched_if bus ();

  sme_sched #(.TMO(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] req;
    logic       src;
    logic       s, p, l;
    logic [7:0] d;
    logic       ev, em;
    logic [4:0] ei;
    logic [1:0] x_gnt;
    logic [7:0] x_ed;
    logic       x_es, x_ep;
    logic [1:0] x_rv;
    logic       x_rm;
    logic [4:0] x_ri;
    logic       x_re, x_bz;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(input logic [1:0] req, input logic src, input logic s, p, l,
                              input logic [7:0] d, input logic ev, em, input logic [4:0] ei,
                              input logic [1:0] gnt, input logic [7:0] ed, input logic es, ep,
                              input logic [1:0] rv, input logic rm, input logic [4:0] ri,
                              input logic re, bz);
    vec_t v;
    v.req = req; v.src = src; v.s = s; v.p = p; v.l = l; v.d = d;
    v.ev = ev; v.em = em; v.ei = ei;
    v.x_gnt = gnt; v.x_ed = ed; v.x_es = es; v.x_ep = ep; v.x_rv = rv;
    v.x_rm = rm; v.x_ri = ri; v.x_re = re; v.x_bz = bz;
    return v;
  endfunction

  // The non-selected requester always carries junk that would be illegal if it were used.
  task automatic drive(input logic [1:0] req, input logic src, input logic s, p, l,
                       input logic [7:0] d, input logic ev, em, input logic [4:0] ei);
    bus.req0 = req[0];
    bus.req1 = req[1];
    if (!src) begin
      bus.in_data0 = d;     bus.in_str0 = s;    bus.in_pat0 = p;    bus.in_last0 = l;
      bus.in_data1 = 8'hFF; bus.in_str1 = 1'b1; bus.in_pat1 = 1'b1; bus.in_last1 = 1'b1;
    end else begin
      bus.in_data1 = d;     bus.in_str1 = s;    bus.in_pat1 = p;    bus.in_last1 = l;
      bus.in_data0 = 8'hFF; bus.in_str0 = 1'b1; bus.in_pat0 = 1'b1; bus.in_last0 = 1'b1;
    end
    bus.eng_valid       = ev;
    bus.eng_match       = em;
    bus.eng_match_index = ei;
  endtask

  task automatic idle(input logic [1:0] req);
    drive(req, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [1:0] gnt, input logic [7:0] ed,
                       input logic es, ep, input logic [1:0] rv, input logic rm,
                       input logic [4:0] ri, input logic re, bz);
    logic [21:0] act, exp;
    act = {bus.gnt1, bus.gnt0, bus.eng_chardata, bus.eng_isstring, bus.eng_ispattern,
           bus.res_valid1, bus.res_valid0, bus.res_match, bus.res_index, bus.res_err, bus.busy};
    exp = {gnt, ed, es, ep, rv, rm, ri, re, bz};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {gnt,ed,es,ep,rv,rm,ri,re,busy} got %b_%h_%b%b_%b_%b_%h_%b_%b required %b_%h_%b%b_%b_%b_%h_%b_%b",
               name, act[21:20], act[19:12], act[11], act[10], act[9:8], act[7], act[6:2],
               act[1], act[0], exp[21:20], exp[19:12], exp[11], exp[10], exp[9:8], exp[7],
               exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.req, v.src, v.s, v.p, v.l, v.d, v.ev, v.em, v.ei);
    step();
    check(name, v.x_gnt, v.x_ed, v.x_es, v.x_ep, v.x_rv, v.x_rm, v.x_ri, v.x_re, v.x_bz);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    idle(2'b00);
    step();
    check(name, 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Job on req0 "ab cd" / "cd", req dropped after grant, engine answers match at 3.
    //             req  src s p l data   ev em ei     gnt   ed     es ep rv    rm ri    re bz
    va.push_back(mk(2'b01, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b01, 8'h00, 0,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 1,0,0, 8'h61, 0,0,5'd0,  2'b01, 8'h61, 1,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 1,0,0, 8'h62, 0,0,5'd0,  2'b01, 8'h62, 1,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 1,0,0, 8'h20, 0,0,5'd0,  2'b01, 8'h20, 1,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 1,0,0, 8'h63, 0,0,5'd0,  2'b01, 8'h63, 1,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 1,0,0, 8'h64, 0,0,5'd0,  2'b01, 8'h64, 1,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 0,1,0, 8'h63, 0,0,5'd0,  2'b01, 8'h63, 0,1, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 0,1,1, 8'h64, 0,0,5'd0,  2'b00, 8'h64, 0,1, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b00, 0,5'd0, 0,1));
    va.push_back(mk(2'b00, 0, 0,0,0, 8'h00, 1,1,5'd3,  2'b00, 8'h00, 0,0, 2'b01, 1,5'd3, 0,1));
    va.push_back(mk(2'b00, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b00, 1,5'd3, 0,0));

    // Round robin with both requesting, then a gap-cycle abort on the third grant.
    vb.push_back(mk(2'b11, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b01, 8'h00, 0,0, 2'b00, 0,5'd0, 0,1));
    vb.push_back(mk(2'b11, 0, 1,0,0, 8'h78, 0,0,5'd0,  2'b01, 8'h78, 1,0, 2'b00, 0,5'd0, 0,1));
    vb.push_back(mk(2'b11, 0, 0,1,1, 8'h79, 0,0,5'd0,  2'b00, 8'h79, 0,1, 2'b00, 0,5'd0, 0,1));
    vb.push_back(mk(2'b11, 0, 0,0,0, 8'h00, 1,0,5'd7,  2'b00, 8'h00, 0,0, 2'b01, 0,5'd7, 0,1));
    vb.push_back(mk(2'b11, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b00, 0,5'd7, 0,0));
    vb.push_back(mk(2'b11, 1, 0,0,0, 8'h00, 0,0,5'd0,  2'b10, 8'h00, 0,0, 2'b00, 0,5'd7, 0,1));
    vb.push_back(mk(2'b11, 1, 1,0,0, 8'h70, 0,0,5'd0,  2'b10, 8'h70, 1,0, 2'b00, 0,5'd7, 0,1));
    vb.push_back(mk(2'b11, 1, 0,1,1, 8'h71, 0,0,5'd0,  2'b00, 8'h71, 0,1, 2'b00, 0,5'd7, 0,1));
    vb.push_back(mk(2'b11, 1, 0,0,0, 8'h00, 1,1,5'd31, 2'b00, 8'h00, 0,0, 2'b10, 1,5'd31, 0,1));
    vb.push_back(mk(2'b11, 1, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b00, 1,5'd31, 0,0));
    vb.push_back(mk(2'b11, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b01, 8'h00, 0,0, 2'b00, 1,5'd31, 0,1));
    vb.push_back(mk(2'b01, 0, 1,0,0, 8'h61, 0,0,5'd0,  2'b01, 8'h61, 1,0, 2'b00, 1,5'd31, 0,1));
    vb.push_back(mk(2'b01, 0, 1,0,0, 8'h62, 0,0,5'd0,  2'b01, 8'h62, 1,0, 2'b00, 1,5'd31, 0,1));
    vb.push_back(mk(2'b01, 0, 1,0,0, 8'h63, 0,0,5'd0,  2'b01, 8'h63, 1,0, 2'b00, 1,5'd31, 0,1));
    vb.push_back(mk(2'b01, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b01, 0,5'd0, 1,1));
    vb.push_back(mk(2'b00, 0, 0,0,0, 8'h00, 0,0,5'd0,  2'b00, 8'h00, 0,0, 2'b00, 0,5'd0, 1,0));

    do_reset("reset_initial");

    foreach (va[i]) apply(va[i], $sformatf("single_job[%0d]", i));

    // Engine silent on a req1 job: result after exactly 64 WAIT cycles.
    apply(mk(2'b10, 1, 0,0,0, 8'h00, 0,0,5'd0, 2'b10, 8'h00, 0,0, 2'b00, 1,5'd3, 0,1), "tmo_grant");
    apply(mk(2'b00, 1, 1,0,0, 8'h73, 0,0,5'd0, 2'b10, 8'h73, 1,0, 2'b00, 1,5'd3, 0,1), "tmo_str");
    apply(mk(2'b00, 1, 0,1,1, 8'h74, 0,0,5'd0, 2'b00, 8'h74, 0,1, 2'b00, 1,5'd3, 0,1), "tmo_pat");
    for (int i = 1; i < 64; i++) begin
      idle(2'b00);
      step();
      check($sformatf("tmo_wait[%0d]", i), 2'b00, 8'h00, 0, 0, 2'b00, 1, 5'd3, 0, 1);
    end
    idle(2'b00);
    step();
    check("tmo_result", 2'b00, 8'h00, 0, 0, 2'b10, 0, 5'd0, 1, 1);
    idle(2'b00);
    step();
    check("tmo_idle", 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 1, 0);

    do_reset("reset_before_rr");

    foreach (vb[i]) apply(vb[i], $sformatf("rr_gap[%0d]", i));

    // 33 string bytes on req1 (pointer now favours req1).
    idle(2'b10);
    step();
    check("str33_grant", 2'b10, 8'h00, 0, 0, 2'b00, 0, 5'd0, 1, 1);
    for (int i = 0; i < 32; i++) begin
      drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i + 1), 1'b0, 1'b0, 5'd0);
      step();
      check($sformatf("str33_byte[%0d]", i), 2'b10, 8'(i + 1), 1, 0, 2'b00, 0, 5'd0, 1, 1);
    end
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 5'd0);
    step();
    check("str33_abort", 2'b00, 8'h00, 0, 0, 2'b10, 0, 5'd0, 1, 1);
    idle(2'b00);
    step();
    check("str33_idle", 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 1, 0);

    // Nine pattern bytes on req0.
    idle(2'b01);
    step();
    check("pat9_grant", 2'b01, 8'h00, 0, 0, 2'b00, 0, 5'd0, 1, 1);
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 5'd0);
    step();
    check("pat9_str", 2'b01, 8'h41, 1, 0, 2'b00, 0, 5'd0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h50 + k), 1'b0, 1'b0, 5'd0);
      step();
      check($sformatf("pat9_byte[%0d]", k), 2'b01, 8'(8'h50 + k), 0, 1, 2'b00, 0, 5'd0, 1, 1);
    end
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h58, 1'b0, 1'b0, 5'd0);
    step();
    check("pat9_abort", 2'b00, 8'h00, 0, 0, 2'b01, 0, 5'd0, 1, 1);
    idle(2'b00);
    step();
    check("pat9_idle", 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 1, 0);

    // Reset while a req1 job is in WAIT with the engine answering in the same cycle.
    apply(mk(2'b10, 1, 0,0,0, 8'h00, 0,0,5'd0, 2'b10, 8'h00, 0,0, 2'b00, 0,5'd0, 1,1), "rst_grant");
    apply(mk(2'b10, 1, 1,0,0, 8'h6B, 0,0,5'd0, 2'b10, 8'h6B, 1,0, 2'b00, 0,5'd0, 1,1), "rst_str");
    apply(mk(2'b10, 1, 0,1,1, 8'h6C, 0,0,5'd0, 2'b00, 8'h6C, 0,1, 2'b00, 0,5'd0, 1,1), "rst_pat");
    apply(mk(2'b00, 1, 0,0,0, 8'h00, 0,0,5'd0, 2'b00, 8'h00, 0,0, 2'b00, 0,5'd0, 1,1), "rst_wait");
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd5);
    step();
    check("rst_mid_wait", 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    reset = 1'b0;
    idle(2'b00);
    step();
    check("rst_no_result", 2'b00, 8'h00, 0, 0, 2'b00, 0, 5'd0, 0, 0);
    idle(2'b10);
    step();
    check("rst_req1_alone", 2'b10, 8'h00, 0, 0, 2'b00, 0, 5'd0, 0, 1);
    do_reset("reset_again");
    idle(2'b11);
    step();
    check("rst_ptr_zero", 2'b01, 8'h00, 0, 0, 2'b00, 0, 5'd0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
